// File: rtl/div_sequencer.sv
// Control sequencer wrapped around the iterative signed divider: latches operands,
// steps the divider through its phases and owns the architectural Hi/Lo registers.
module div_sequencer #(
  parameter int WIDTH       = 32,
  parameter int ITER_CYCLES = 30
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divider,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [1:0]       DivtoControl,
  input  logic [WIDTH-1:0] DivHi,
  input  logic [WIDTH-1:0] DivLo,
  output logic [1:0]       DivState,
  output logic [WIDTH-1:0] DividendQ,
  output logic [WIDTH-1:0] DividerQ,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EVAL, S_INIT, S_ITER, S_FINAL, S_WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divider_q, divider_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [1:0]         div_state_q, div_state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               zero_seen;

  assign zero_seen = (DivtoControl == 2'b10);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divider_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      div_state_q <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divider_q   <= divider_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_state_q <= div_state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // The iterate phase ends on the internal counter; the divider's completion flag is not trusted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CHECK;
      S_CHECK: state_d = S_EVAL;
      S_EVAL: begin
        if (zero_seen) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(ITER_CYCLES - 1);
          state_d = S_INIT;
        end
      end
      S_INIT:  state_d = S_ITER;
      S_ITER: begin
        if (cnt_q == '0) state_d = S_FINAL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FINAL: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so DivState and Busy come straight from flops.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    div_state_d = 2'b00;
    case (state_d)
      S_INIT:  div_state_d = 2'b01;
      S_ITER:  div_state_d = 2'b10;
      S_FINAL: div_state_d = 2'b11;
      default: div_state_d = 2'b00;
    endcase
  end

  // mthi/mtlo are honoured only while idle, so a division result can never collide with them.
  always_comb begin
    dividend_d = dividend_q;
    divider_d  = divider_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = (state_q == S_WRITE);
    div_zero_d = (state_q == S_EVAL) && zero_seen;
    if (state_q == S_IDLE) begin
      if (Start) begin
        dividend_d = Dividend;
        divider_d  = Divider;
      end
      if (HiWrite) hi_d = WriteData;
      if (LoWrite) lo_d = WriteData;
    end
    if (state_q == S_WRITE) begin
      hi_d = DivHi;
      lo_d = DivLo;
    end
  end

  assign DivState  = div_state_q;
  assign DividendQ = dividend_q;
  assign DividerQ  = divider_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = div_zero_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider model, vector table and a result
// scoreboard popped on every Done/DivZero pulse.
module tb_div_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] Dividend;
  logic [31:0] Divider;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] WriteData;
  logic [1:0]  DivtoControl;
  logic [31:0] DivHi = 32'h0;
  logic [31:0] DivLo = 32'h0;
  logic [1:0]  DivState;
  logic [31:0] DividendQ;
  logic [31:0] DividerQ;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  typedef struct {
    bit          isZero;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    bit          isZero;
    logic [31:0] eHi;
    logic [31:0] eLo;
    int          opts;
  } vec_t;

  exp_t        sbQueue[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] hiModel;
  logic [31:0] loModel;
  bit          monitorOn = 1'b0;

  div_sequencer #(.WIDTH(32), .ITER_CYCLES(30)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Dividend(Dividend), .Divider(Divider),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .DivtoControl(DivtoControl), .DivHi(DivHi), .DivLo(DivLo),
    .DivState(DivState), .DividendQ(DividendQ), .DividerQ(DividerQ),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  // Divider model: flags a zero divisor while in the 00 codes, and only publishes a real
  // result at the end of FINAL; INIT scrambles the outputs so early capture shows up.
  assign DivtoControl = (DivState == 2'b00 && DividerQ == 32'd0) ? 2'b10 :
                        ((DivState == 2'b11) ? 2'b01 : 2'b00);

  always @(posedge Clock) begin
    if (DivState == 2'b11 && DividerQ != 32'd0) begin
      DivHi <= $signed(DividendQ) % $signed(DividerQ);
      DivLo <= $signed(DividendQ) / $signed(DividerQ);
    end else if (DivState == 2'b01) begin
      DivHi <= 32'hDEAD0001;
      DivLo <= 32'hDEAD0002;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (monitorOn && (Done || DivZero)) begin
      checkOutput("done_zero_exclusive", {31'b0, Done & DivZero}, 32'd0);
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got Done=%0b DivZero=%0b, expected no pulse", Done, DivZero);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("pulse_kind", {31'b0, DivZero}, {31'b0, e.isZero});
        checkOutput("hi_result", Hi, e.hi);
        checkOutput("lo_result", Lo, e.lo);
      end
    end
  end

  // opts: 1 = change Dividend mid-op, 2 = mtlo during ITER, 4 = Start pulse at E10
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input bit isZero,
                               input logic [31:0] eHi, input logic [31:0] eLo, input int opts);
    int          k;
    int          latency;
    int          seqErrs;
    int          busyErrs;
    logic [1:0]  expCode;
    logic [31:0] loPrev;
    exp_t        e;
    loPrev   = loModel;
    e.isZero = isZero;
    if (isZero) begin
      e.hi = hiModel;
      e.lo = loModel;
    end else begin
      e.hi    = eHi;
      e.lo    = eLo;
      hiModel = eHi;
      loModel = eLo;
    end
    sbQueue.push_back(e);
    Dividend = dvd;
    Divider  = dvs;
    Start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start    = 1'b0;
    seqErrs  = 0;
    busyErrs = 0;
    latency  = -1;
    for (k = 0; k <= 60; k++) begin
      if (isZero)                expCode = 2'b00;
      else if (k == 2)           expCode = 2'b01;
      else if (k >= 3 && k <= 32) expCode = 2'b10;
      else if (k == 33)          expCode = 2'b11;
      else                       expCode = 2'b00;
      if (DivState !== expCode) seqErrs++;
      if (Done || DivZero) begin
        latency = k;
        if (Busy !== 1'b0) busyErrs++;
        break;
      end
      if (Busy !== 1'b1) busyErrs++;
      if ((opts & 1) != 0 && k == 4)  Dividend = 32'h0000_1234;
      if ((opts & 2) != 0 && k == 10) begin
        LoWrite   = 1'b1;
        WriteData = 32'h5A5A_5A5A;
      end
      if ((opts & 2) != 0 && k == 11) LoWrite = 1'b0;
      if ((opts & 2) != 0 && k == 12) checkOutput("lo_write_ignored_busy", Lo, loPrev);
      if ((opts & 4) != 0 && k == 9)  Start = 1'b1;
      if ((opts & 4) != 0 && k == 10) Start = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
    end
    checkOutput("latency", latency, isZero ? 32'd2 : 32'd35);
    checkOutput("divstate_seq_errors", seqErrs, 32'd0);
    checkOutput("busy_profile_errors", busyErrs, 32'd0);
    checkOutput("dividend_frozen", DividendQ, dvd);
    checkOutput("divider_frozen", DividerQ, dvs);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("pulse_drops", {30'b0, Done, DivZero}, 32'd0);
  endtask

  initial begin
    int firstT;
    int secondT;
    Reset = 1'b0; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    Dividend = '0; Divider = '0; WriteData = '0;
    hiModel = '0; loModel = '0;
    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        0};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,         1'b0, 32'hFFFFFFFE,  32'hFFFFFFF2,  5};
    vecs[2] = '{32'd5,         32'd0,         1'b1, 32'd0,         32'd0,         0};
    vecs[3] = '{32'd7,         32'hFFFFFFFE,  1'b0, 32'd1,         32'hFFFFFFFD,  2};
    vecs[4] = '{32'hFFFFFFD3,  32'hFFFFFFFA,  1'b0, 32'hFFFFFFFD,  32'd7,         0};
    vecs[5] = '{32'd12345,     32'd1000,      1'b0, 32'd345,       32'd12,        0};

    repeat (2) @(negedge Clock);
    checkOutput("rst_divstate", {30'b0, DivState}, 32'd0);
    checkOutput("rst_flags", {29'b0, Busy, Done, DivZero}, 32'd0);
    checkOutput("rst_hi", Hi, 32'd0);
    checkOutput("rst_lo", Lo, 32'd0);
    checkOutput("rst_operands", DividendQ | DividerQ, 32'd0);
    Reset = 1'b1;
    monitorOn = 1'b1;
    @(negedge Clock);

    HiWrite = 1'b1; WriteData = 32'hAAAA_5555;
    @(posedge Clock); @(negedge Clock);
    HiWrite = 1'b0;
    checkOutput("mthi", Hi, 32'hAAAA_5555);
    checkOutput("mthi_lo_untouched", Lo, 32'd0);
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h1357_9BDF;
    @(posedge Clock); @(negedge Clock);
    HiWrite = 1'b0; LoWrite = 1'b0;
    checkOutput("mthi_both", Hi, 32'h1357_9BDF);
    checkOutput("mtlo_both", Lo, 32'h1357_9BDF);
    hiModel = 32'h1357_9BDF; loModel = 32'h1357_9BDF;

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].dvd, vecs[i].dvs, vecs[i].isZero, vecs[i].eHi, vecs[i].eLo, vecs[i].opts);

    // Start held high: two back-to-back divisions
    sbQueue.push_back('{1'b0, 32'd2, 32'd14});
    sbQueue.push_back('{1'b0, 32'd2, 32'd14});
    hiModel = 32'd2; loModel = 32'd14;
    Dividend = 32'd100; Divider = 32'd7; Start = 1'b1;
    @(posedge Clock); @(negedge Clock);
    firstT = -1; secondT = -1;
    for (int t = 0; t < 100; t++) begin
      if (Done) begin
        if (firstT < 0) firstT = t;
        else begin
          secondT = t;
          Start = 1'b0;
          break;
        end
      end
      @(posedge Clock); @(negedge Clock);
    end
    Start = 1'b0;
    checkOutput("b2b_first_done", firstT, 32'd35);
    checkOutput("b2b_period", secondT - firstT, 32'd36);
    repeat (3) @(negedge Clock);

    // Asynchronous reset in the middle of ITER abandons the division
    Dividend = 32'd100; Divider = 32'd7; Start = 1'b1;
    @(posedge Clock); @(negedge Clock);
    Start = 1'b0;
    repeat (19) begin @(posedge Clock); @(negedge Clock); end
    checkOutput("pre_reset_iter", {30'b0, DivState}, 32'd2);
    #2 Reset = 1'b0;
    #1;
    checkOutput("midrst_divstate", {30'b0, DivState}, 32'd0);
    checkOutput("midrst_busy", {31'b0, Busy}, 32'd0);
    checkOutput("midrst_hi", Hi, 32'd0);
    checkOutput("midrst_lo", Lo, 32'd0);
    hiModel = '0; loModel = '0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 0);

    repeat (40) @(negedge Clock);
    checkOutput("scoreboard_empty", sbQueue.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control stage directly upstream and downstream of the iterative signed divider.
- Latches operands on a Start request and drives the divider's 2-bit state code through check, init, iterate and final phases.
- Captures the divider's quotient/remainder into the architectural Hi/Lo registers.
- Reports Busy, Done and divide-by-zero to the main control unit; also services mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand and Hi/Lo width.
- ITER_CYCLES, 30, number of cycles the divider is held in the iterate code (state 10).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request a division; sampled only in IDLE.
- Dividend  in  WIDTH  dividend operand from the register file.
- Divider  in  WIDTH  divisor operand from the register file.
- HiWrite  in  1  mthi write strobe.
- LoWrite  in  1  mtlo write strobe.
- WriteData  in  WIDTH  data for mthi/mtlo.
- DivtoControl  in  2  status from the divider: 10 = divisor zero, 01 = iterations complete.
- DivHi  in  WIDTH  divider remainder output.
- DivLo  in  WIDTH  divider quotient output.
- DivState  out  2  state code to the divider: 00 check, 01 init, 10 iterate, 11 final.
- DividendQ  out  WIDTH  latched dividend, held stable to the divider.
- DividerQ  out  WIDTH  latched divisor, held stable to the divider.
- Busy  out  1  division in progress.
- Done  out  1  one-cycle pulse: Hi/Lo updated with a division result.
- DivZero  out  1  one-cycle pulse: divide-by-zero detected, Hi/Lo unchanged.
- Hi  out  WIDTH  architectural Hi register.
- Lo  out  WIDTH  architectural Lo register.

Behaviour:
- Reset (Reset=0, asynchronous):
  - FSM goes to IDLE.
  - DivState=00, Busy=0, Done=0, DivZero=0.
  - Hi, Lo, DividendQ, DividerQ all = 0.
  - Also applies mid-operation: the in-flight division is abandoned and Hi/Lo are not written.
- All other state changes occur on the rising edge of Clock. All outputs are registered.
- FSM states and the DivState code driven in each:
  - IDLE (00): on Start, latch Dividend/Divider into DividendQ/DividerQ, set Busy=1, go to CHECK.
  - CHECK (00): one cycle; the divider evaluates the latched divisor. Go to EVAL.
  - EVAL (00): sample DivtoControl.
    - If 10: pulse DivZero, clear Busy, go to IDLE.
    - Otherwise: load the iteration counter with ITER_CYCLES-1, go to INIT.
  - INIT (01): one cycle. Go to ITER.
  - ITER (10): decrement the counter each cycle; go to FINAL after exactly ITER_CYCLES cycles.
  - FINAL (11): one cycle; the divider updates DivHi/DivLo at the end of this cycle. Go to WRITE.
  - WRITE (00): Hi<=DivHi, Lo<=DivLo, pulse Done, clear Busy, go to IDLE.
- DivtoControl is not used to end ITER; the internal counter governs.
- Latency, with Start sampled at edge E0:
  - Normal division: Hi/Lo updated, Done=1 and Busy=0 after edge E0+ITER_CYCLES+5 (E35 at the default). Done drops at the next edge.
  - Divide-by-zero: DivZero=1 and Busy=0 after edge E2. DivZero lasts one cycle.
- Start handling:
  - Start while Busy=1 is ignored; DividendQ/DividerQ stay frozen for the whole operation.
  - Start held high in IDLE starts a new division each time IDLE is re-entered.
- mthi/mtlo:
  - HiWrite/LoWrite take effect at the next edge only when the FSM is in IDLE (including the cycle Start is sampled). Both may write in the same cycle.
  - In any other state they are ignored; no queuing.
- In WRITE, the division result always wins over a same-cycle HiWrite/LoWrite, because the strobes are ignored outside IDLE.
- Done and DivZero are never high in the same cycle.

Test Plan:
- 100 / 7 with a bench divider model returning DivHi=2, DivLo=14: DivState sequence 00,00,00,01,10×30,11,00; Hi=2, Lo=14, Done pulses after E35.
- -100 / 7, model returns DivHi=0xFFFFFFFE, DivLo=0xFFFFFFF2: Hi/Lo equal those values at E35. Change Dividend at E5 → DividendQ stays 0xFFFFFF9C.
- Divider=0, model drives DivtoControl=10 during EVAL: DivZero pulses after E2, Busy falls, Hi/Lo keep prior values, DivState never leaves 00.
- Preload: HiWrite=1 with WriteData=0xAAAA5555 in IDLE → Hi=0xAAAA5555. Then LoWrite=1 pulsed during ITER → Lo unchanged, and after completion Lo=DivLo.
- Start pulsed again at E10 during a division: ignored, exactly one Done pulse. Start held high: back-to-back divisions, Done every 36 cycles.
- Reset=0 at E20 mid-ITER: immediately DivState=00, Busy=0, Hi=Lo=0. After release, Start performs a clean full division.
